// File: rtl/dll_pkg.sv
// dll_pkg: shared DLLP encodings, FSM state codes and sequence arithmetic for the data-link layer
package dll_pkg;
  localparam logic [1:0] DLLP_NONE = 2'b00;
  localparam logic [1:0] DLLP_ACK = 2'b01;
  localparam logic [1:0] DLLP_NAK = 2'b10;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND_ACK = 2'd1;
  localparam logic [1:0] ST_SEND_NAK = 2'd2;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND_ACK = ST_SEND_ACK,
    SEND_NAK = ST_SEND_NAK
  } state_t;
  // callers truncate the result to their sequence width to get the modulo distance
  function automatic logic [31:0] seq_dist(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction
endpackage

// File: rtl/ack_lat_timer.sv
// ack_lat_timer: ACK coalescing counter that saturates at ACK_LAT-1 and flags expiry
module ack_lat_timer #(
  parameter int ACK_LAT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int W = $clog2(ACK_LAT) + 1;
  logic [W-1:0] r_cnt;
  assign o_expire = r_cnt == W'(ACK_LAT - 1);
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_enable && !o_expire) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/ack_nak_gen.sv
// ack_nak_gen: receive-side TLP sequence/LCRC checker that schedules ACK/NAK DLLPs
module ack_nak_gen
  import dll_pkg::*;
#(
  parameter int SEQ_W = 12,
  parameter int ACK_LAT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_tlp_valid,
  input  logic [SEQ_W-1:0] i_tlp_seq,
  input  logic             i_lcrc_ok,
  output logic             o_fwd_accept,
  output logic             o_dllp_valid,
  input  logic             i_dllp_rdy,
  output logic [1:0]       o_dllp_type,
  output logic [SEQ_W-1:0] o_dllp_seq,
  output logic [SEQ_W-1:0] o_next_rcv_seq,
  output logic             o_nak_scheduled
);
  localparam logic [SEQ_W-1:0] HALF = {1'b1, {(SEQ_W-1){1'b0}}};
  state_t r_state, w_state_nxt;
  logic [SEQ_W-1:0] r_next, r_dllp_seq, w_d;
  logic r_fwd, r_nak_sched, r_nak_req, r_ack_pend, r_ack_force;
  logic w_good, w_dup, w_bad, w_expire, w_force, w_go_ack, w_go_nak;
  assign w_d = SEQ_W'(seq_dist(32'(r_next), 32'(i_tlp_seq)));
  assign w_good = i_tlp_valid && i_lcrc_ok && w_d == '0;
  assign w_dup = i_tlp_valid && i_lcrc_ok && w_d != '0 && w_d <= HALF;
  assign w_bad = i_tlp_valid && !w_good && !w_dup;
  assign w_force = r_ack_force || (r_ack_pend && w_expire);
  ack_lat_timer #(.ACK_LAT(ACK_LAT)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (!r_ack_pend || w_go_ack),
    .i_enable (r_ack_pend && r_state == IDLE),
    .o_expire (w_expire)
  );
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    w_go_nak = 1'b0;
    w_go_ack = 1'b0;
    if (r_state == IDLE) begin
      w_go_nak = r_nak_req;
      w_go_ack = !r_nak_req && w_force;
      w_state_nxt = r_nak_req ? SEND_NAK : w_force ? SEND_ACK : IDLE;
    end else if (i_dllp_rdy) begin
      w_state_nxt = IDLE;
    end
  end
  // a new TLP's flags win over the clear done on state entry in the same cycle
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_fwd <= 1'b0;
      r_next <= '0;
      r_dllp_seq <= '1;
      r_nak_req <= 1'b0;
      r_nak_sched <= 1'b0;
      r_ack_pend <= 1'b0;
      r_ack_force <= 1'b0;
    end else begin
      r_fwd <= w_good;
      if (w_good) r_next <= r_next + 1'b1;
      if (w_go_ack || w_go_nak) r_dllp_seq <= r_next - 1'b1;
      r_nak_req <= (r_nak_req && !w_go_nak) || (w_bad && !r_nak_sched && r_state != SEND_NAK);
      r_ack_force <= (r_ack_force && !w_go_ack && !w_go_nak) || w_dup;
      r_ack_pend <= (r_ack_pend && !w_go_ack) || w_good;
      r_nak_sched <= !w_good && (r_nak_sched || (r_state == SEND_NAK && i_dllp_rdy));
    end
  end
  assign o_fwd_accept = r_fwd;
  assign o_dllp_valid = r_state != IDLE;
  assign o_dllp_type = r_state == SEND_ACK ? DLLP_ACK : r_state == SEND_NAK ? DLLP_NAK : DLLP_NONE;
  assign o_dllp_seq = r_dllp_seq;
  assign o_next_rcv_seq = r_next;
  assign o_nak_scheduled = r_nak_sched;
endmodule

// File: tb/tb_ack_nak_gen.sv
// tb_ack_nak_gen: scoreboard bench; stimulus queues expected DLLPs, a monitor checks each handshake
module tb_ack_nak_gen;
  logic clk, reset_n, tlp_valid, lcrc_ok, dllp_rdy;
  logic [11:0] tlp_seq;
  logic fwd_accept, dllp_valid, nak_scheduled;
  logic [1:0] dllp_type;
  logic [11:0] dllp_seq, next_rcv_seq;
  logic [13:0] exp_q[$];
  logic [13:0] mon_exp;
  logic sb_on;
  int n_chk = 0;
  int n_fail = 0;

  ack_nak_gen #(.SEQ_W(12), .ACK_LAT(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_tlp_valid     (tlp_valid),
    .i_tlp_seq       (tlp_seq),
    .i_lcrc_ok       (lcrc_ok),
    .o_fwd_accept    (fwd_accept),
    .o_dllp_valid    (dllp_valid),
    .i_dllp_rdy      (dllp_rdy),
    .o_dllp_type     (dllp_type),
    .o_dllp_seq      (dllp_seq),
    .o_next_rcv_seq  (next_rcv_seq),
    .o_nak_scheduled (nak_scheduled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dllp_valid && dllp_rdy && sb_on) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dllp_unexpected: got type %0d seq %0d, expected no DLLP", dllp_type, dllp_seq);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({dllp_type, dllp_seq} !== mon_exp) begin
          n_fail++;
          $display("FAIL dllp_handshake: got type %0d seq %0d, expected type %0d seq %0d",
                   dllp_type, dllp_seq, mon_exp[13:12], mon_exp[11:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [11:0] s, input logic ok);
    tlp_valid = 1'b1;
    tlp_seq = s;
    lcrc_ok = ok;
    tick(1);
    tlp_valid = 1'b0;
  endtask

  task automatic feed(input int first, input int last);
    for (int i = first; i <= last; i++) send(12'(i), 1'b1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
    tick(1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d DLLPs outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    tick(2);
    reset_n = 1'b0;
    tick(1);
  endtask

  initial begin
    reset_n = 1'b1;
    tlp_valid = 1'b0;
    tlp_seq = '0;
    lcrc_ok = 1'b0;
    dllp_rdy = 1'b0;
    sb_on = 1'b1;
    tick(3);
    chk("rst_valid", 32'(dllp_valid), 0);
    chk("rst_type", 32'(dllp_type), 0);
    chk("rst_seq", 32'(dllp_seq), 4095);
    chk("rst_next", 32'(next_rcv_seq), 0);
    chk("rst_nak", 32'(nak_scheduled), 0);
    chk("rst_fwd", 32'(fwd_accept), 0);
    reset_n = 1'b0;
    tick(1);
    // first good TLP, ACK after the coalescing window
    send(12'd0, 1'b1);
    chk("t1_fwd", 32'(fwd_accept), 1);
    chk("t1_next", 32'(next_rcv_seq), 1);
    exp_q.push_back({2'b01, 12'd0});
    tick(1);
    chk("t1_fwd_pulse", 32'(fwd_accept), 0);
    tick(6);
    chk("t1_not_yet", 32'(dllp_valid), 0);
    tick(1);
    chk("t1_valid", 32'(dllp_valid), 1);
    chk("t1_type", 32'(dllp_type), 1);
    chk("t1_seq", 32'(dllp_seq), 0);
    dllp_rdy = 1'b1;
    tick(1);
    chk("t1_drop", 32'(dllp_valid), 0);
    drain(5);
    // coalesced ACK
    do_reset();
    feed(0, 3);
    exp_q.push_back({2'b01, 12'd3});
    chk("t2_next", 32'(next_rcv_seq), 4);
    drain(20);
    // out-of-sequence NAK and suppression
    do_reset();
    feed(0, 4);
    exp_q.push_back({2'b01, 12'd4});
    drain(20);
    chk("t3_next", 32'(next_rcv_seq), 5);
    send(12'd7, 1'b1);
    chk("t3_no_fwd", 32'(fwd_accept), 0);
    exp_q.push_back({2'b10, 12'd4});
    drain(10);
    chk("t3_nak_sched", 32'(nak_scheduled), 1);
    send(12'd5, 1'b0);
    tick(12);
    chk("t3_nak_held", 32'(nak_scheduled), 1);
    send(12'd5, 1'b1);
    chk("t3_fwd", 32'(fwd_accept), 1);
    chk("t3_next6", 32'(next_rcv_seq), 6);
    chk("t3_nak_clr", 32'(nak_scheduled), 0);
    exp_q.push_back({2'b01, 12'd5});
    drain(20);
    // duplicate forces immediate ACK
    do_reset();
    feed(0, 4);
    exp_q.push_back({2'b01, 12'd4});
    drain(20);
    send(12'd2, 1'b1);
    exp_q.push_back({2'b01, 12'd4});
    chk("t4_no_fwd", 32'(fwd_accept), 0);
    chk("t4_next", 32'(next_rcv_seq), 5);
    tick(1);
    chk("t4_imm_valid", 32'(dllp_valid), 1);
    chk("t4_imm_seq", 32'(dllp_seq), 4);
    drain(10);
    // sequence wrap
    do_reset();
    sb_on = 1'b0;
    feed(0, 4094);
    tick(20);
    sb_on = 1'b1;
    chk("t5_next", 32'(next_rcv_seq), 4095);
    send(12'd4095, 1'b1);
    chk("t5_fwd_wrap", 32'(fwd_accept), 1);
    chk("t5_next_wrap", 32'(next_rcv_seq), 0);
    send(12'd0, 1'b1);
    chk("t5_fwd0", 32'(fwd_accept), 1);
    chk("t5_next1", 32'(next_rcv_seq), 1);
    exp_q.push_back({2'b01, 12'd0});
    drain(20);
    // back-pressure, then reset during a held request
    do_reset();
    feed(0, 2);
    exp_q.push_back({2'b01, 12'd2});
    drain(20);
    dllp_rdy = 1'b0;
    send(12'd3, 1'b1);
    tick(8);
    chk("t6_valid", 32'(dllp_valid), 1);
    chk("t6_seq", 32'(dllp_seq), 3);
    send(12'd4, 1'b1);
    send(12'd5, 1'b1);
    chk("t6_fwd_bp", 32'(fwd_accept), 1);
    chk("t6_next", 32'(next_rcv_seq), 6);
    tick(8);
    chk("t6_frozen_seq", 32'(dllp_seq), 3);
    chk("t6_frozen_type", 32'(dllp_type), 1);
    exp_q.push_back({2'b01, 12'd3});
    exp_q.push_back({2'b01, 12'd5});
    dllp_rdy = 1'b1;
    drain(30);
    dllp_rdy = 1'b0;
    send(12'd6, 1'b1);
    tick(8);
    chk("t6_wait_valid", 32'(dllp_valid), 1);
    #2 reset_n = 1'b1;
    #1;
    chk("t6_async_drop", 32'(dllp_valid), 0);
    chk("t6_async_next", 32'(next_rcv_seq), 0);
    tick(1);
    reset_n = 1'b0;
    dllp_rdy = 1'b1;
    tick(12);
    chk("t6_quiet", 32'(dllp_valid), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
